// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller for a cascade of mod-N digit counters.
// Conditions two raw buttons, sequences a 3-state FSM and drives the tick/carry chain.
module stopwatch_ctrl #(
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned PS_WID   = 17,
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_run,
  input  logic                btn_clear,
  input  logic [N_DIGITS-1:0] digit_rollover,
  output logic [N_DIGITS-1:0] digit_inc,
  output logic                digit_clear,
  output logic                running,
  output logic                overflow
);

  typedef enum logic [1:0] {
    StIdle,
    StRunning,
    StPaused
  } state_e;

  localparam logic [PS_WID-1:0] PsMax = PS_WID'(PRESCALE - 1);

  state_e              r_state;
  logic                r_running;
  logic                r_digit_clear;
  logic                r_overflow;
  logic [PS_WID-1:0]   r_ps;
  // Bit 0 = first synchroniser stage, bit 1 = second, bit 2 = edge-detect delay.
  logic [2:0]          r_run_sync;
  logic [2:0]          r_clr_sync;

  logic                w_run_ev;
  logic                w_clr_ev;
  logic                w_clr_accept;
  logic                w_tick;
  logic [N_DIGITS-1:0] w_inc;
  logic                w_chain_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_sync <= '0;
      r_clr_sync <= '0;
    end else begin
      r_run_sync <= {r_run_sync[1:0], btn_run};
      r_clr_sync <= {r_clr_sync[1:0], btn_clear};
    end
  end

  assign w_run_ev     = r_run_sync[1] & ~r_run_sync[2];
  assign w_clr_ev     = r_clr_sync[1] & ~r_clr_sync[2];
  // Clearing a live count is refused; the user must pause first.
  assign w_clr_accept = w_clr_ev && (r_state != StRunning);

  assign w_tick = r_running && (r_ps == PsMax);

  always_comb begin
    w_inc    = '0;
    w_inc[0] = w_tick;
    for (int i = 1; i < int'(N_DIGITS); i++) begin
      w_inc[i] = w_inc[i-1] & digit_rollover[i-1];
    end
  end

  assign w_chain_wrap = w_inc[N_DIGITS-1] & digit_rollover[N_DIGITS-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_running     <= 1'b0;
      r_digit_clear <= 1'b1;
      r_overflow    <= 1'b0;
      r_ps          <= '0;
    end else begin
      r_digit_clear <= w_clr_accept;
      if (w_clr_accept) begin
        // Clear beats a coincident run event, which is dropped.
        r_state    <= StIdle;
        r_running  <= 1'b0;
        r_overflow <= 1'b0;
        r_ps       <= '0;
      end else begin
        if (r_state == StRunning) begin
          r_ps <= (r_ps == PsMax) ? '0 : r_ps + 1'b1;
        end
        if (w_chain_wrap) begin
          r_overflow <= 1'b1;
        end
        if (w_run_ev) begin
          unique case (r_state)
            StIdle: begin
              r_state   <= StRunning;
              r_running <= 1'b1;
            end
            StRunning: begin
              r_state   <= StPaused;
              r_running <= 1'b0;
            end
            StPaused: begin
              r_state   <= StRunning;
              r_running <= 1'b1;
            end
            default: begin
              r_state   <= StIdle;
              r_running <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign digit_inc   = w_inc;
  assign digit_clear = r_digit_clear;
  assign running     = r_running;
  assign overflow    = r_overflow;

endmodule
